load_align_merge: RTL and testbench
===================================

# load_align_merge

Load-side counterpart to the store-data replication path in the LSU. It takes one or two LLEN-wide read beats from the data cache and merges them for loads that cross an LLEN boundary. It then shifts the addressed bytes to bit 0 and sign- or zero-extends per funct3. The result goes back to the pipeline over a valid/ready handshake. It sits between the D$ read-data mux and the load writeback register in the LSU.

## Interface
- LLEN, 64, load/store datapath width in bits; legal values 32 or 64.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  new load request.
- ReqReady  out  1  block can accept a request.
- Funct3  in  3  RISC-V load funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- Offset  in  $clog2(LLEN/8)  byte offset of the load within the first beat.
- BeatValid  in  1  cache read beat present on BeatData.
- BeatData  in  LLEN  cache read data, little-endian.
- BeatReq  out  1  request for the second beat (next LLEN-aligned address).
- Flush  in  1  abandon the in-flight load.
- RespValid  out  1  result valid.
- RespReady  in  1  consumer accepts the result.
- RespData  out  LLEN  aligned, extended load data.
- Misaligned  out  1  boundary-crossing load rejected; valid with RespValid.

## Operation
- Size in bytes: 1 << Funct3[1:0].
  - When LLEN=32, Funct3[1:0]=11 is treated as a word.
  - Funct3 and Offset are captured on a request handshake (ReqValid & ReqReady).
- Span condition: Offset + size > LLEN/8.
- States:
  - IDLE: ReqReady=1. On handshake, go to BEAT0.
  - BEAT0: wait for BeatValid and capture the beat into Hold0.
    - If the load spans and the macro is defined, go to BEAT1.
    - Otherwise compute the result and go to RESP.
  - BEAT1: BeatReq=1 until BeatValid. On BeatValid, merge with Hold0, compute the result and go to RESP.
  - RESP: RespValid=1. On RespReady, go to IDLE.
- Merge: form {beat1, beat0} (2·LLEN bits) and shift right by Offset·8; keep the low LLEN bits. Beat1 is zero for single-beat loads.
- Extend: keep the low size·8 bits.
  - Funct3[2]=0: sign-extend from the top kept bit.
  - Funct3[2]=1: zero-extend.
  - When size = LLEN/8, Funct3[2] is ignored.
- Flush in any non-IDLE state: go to IDLE next cycle, drop any pending result, RespValid=0. A BeatValid in the same cycle is ignored.
- BeatValid in IDLE or RESP is ignored.

## Timing
- Reset state: IDLE.
  - Reset values: ReqReady=1, BeatReq=0, RespValid=0, RespData=0, Misaligned=0.
  - Hold0 cleared.
  - Reset asserted mid-operation takes effect immediately; the load is lost.
- RespData and Misaligned are registered; they update on the BEAT0/BEAT1 → RESP transition.
- Latency, non-spanning load: RespValid rises the cycle after the BEAT0 BeatValid.
- Latency, spanning load: RespValid rises the cycle after the BEAT1 BeatValid.
  - Minimum is request + 3 cycles, given that BeatValid can only be captured in the cycle after the request.
- BeatReq is combinational from state, high for the whole BEAT1 dwell. Exactly one second beat is requested per spanning load.
- RespData and Misaligned stay stable while RespValid=1 & RespReady=0.
- ReqReady is high only in IDLE. There is no pipelining and no same-cycle accept of a new request on RESP exit.

## Configuration
- WALLY_MISALIGNED_LOAD_EN
  - Defined: spanning loads are serviced with two beats, as above.
  - Undefined: BEAT1 is unreachable and BeatReq is tied 0. A spanning load goes BEAT0 → RESP with Misaligned=1 and RespData=0, so the trap logic raises a load-address-misaligned exception.

## Structure
- Shared LSU package:
  - funct3 load encodings.
  - State enum: IDLE, BEAT0, BEAT1, RESP.
  - Size-decode constant.
- One sub-module, subword_extend (combinational):
  - Inputs: shifted LLEN data and Funct3.
  - Output: the extended result.
  - Reusable by the FPU load path.
- The FSM, Hold0, merge shifter and output registers live in load_align_merge.

## Test plan
All values for LLEN=64.
- lb, Offset=3, BeatData=0x00000000_F0000000 → RespData=0xFFFFFFFF_FFFFFFF0, one cycle after BeatValid. Repeated as lbu → 0x00000000_000000F0. BeatReq stays 0.
- lw, Offset=6, beat0=0xAABB0000_00000000, beat1=0x00000000_0000CCDD, macro defined → BeatReq for one BEAT1 dwell, RespData=0xFFFFFFFF_CCDDAABB, Misaligned=0. Repeated as lwu → 0x00000000_CCDDAABB.
- Same spanning lw with the macro undefined → BeatReq never asserted, RespValid with Misaligned=1, RespData=0.
- ld, Offset=0, BeatData=0x8123456789ABCDEF, RespReady held low 3 cycles → RespValid and RespData constant at 0x8123456789ABCDEF, ReqReady=0. Back to IDLE on the cycle RespReady=1.
- Flush asserted in BEAT1 together with BeatValid → IDLE next cycle, no RespValid. A following lh, Offset=0, BeatData=0x7FFF → RespData=0x7FFF.
- reset asserted asynchronously during BEAT1 → all outputs at reset values immediately. After release, a lb completes normally.

Source files
------------

// File: rtl/load_align_merge_pkg.sv
// Shared LSU load-path definitions: funct3 encodings, load FSM states, access-size decode.
package load_align_merge_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_e;

    localparam logic [3:0] SIZE_BYTES [4] = '{4'd1, 4'd2, 4'd4, 4'd8};

    // A doubleword on a 32-bit datapath collapses to a word.
    function automatic logic [3:0] load_size(input logic [1:0] sz, input int llen);
        load_size = (llen == 32 && sz == 2'b11) ? 4'd4 : SIZE_BYTES[sz];
    endfunction

endpackage

// File: rtl/load_align_merge_if.sv
// Pipeline/D$ facing signals of the load align/merge block.
interface load_align_merge_if #(parameter int LLEN = 64);
    localparam int OFFW = $clog2(LLEN/8);

    logic            ReqValid;
    logic            ReqReady;
    logic [2:0]      Funct3;
    logic [OFFW-1:0] Offset;
    logic            BeatValid;
    logic [LLEN-1:0] BeatData;
    logic            BeatReq;
    logic            Flush;
    logic            RespValid;
    logic            RespReady;
    logic [LLEN-1:0] RespData;
    logic            Misaligned;

    modport master (
        output ReqValid, Funct3, Offset, BeatValid, BeatData, Flush, RespReady,
        input  ReqReady, BeatReq, RespValid, RespData, Misaligned
    );

    modport slave (
        input  ReqValid, Funct3, Offset, BeatValid, BeatData, Flush, RespReady,
        output ReqReady, BeatReq, RespValid, RespData, Misaligned
    );
endinterface

// File: rtl/load_align_merge_subword_extend.sv
// subword_extend: keeps the low 1/2/4/8 bytes of aligned load data and sign/zero-extends.
module subword_extend
    import load_align_merge_pkg::*;
#(
    parameter int LLEN = 64
) (
    input  logic [LLEN-1:0] data_i,
    input  logic [2:0]      funct3_i,
    output logic [LLEN-1:0] ext_o
);
    logic [LLEN-1:0] mask;
    logic            sign;

    // A full-width access gets an all-ones mask, so the extension kind drops out.
    always_comb begin
        mask = '1;
        sign = 1'b0;
        unique case (funct3_i[1:0])
            2'b00: begin mask = LLEN'(64'hFF);        sign = data_i[7];  end
            2'b01: begin mask = LLEN'(64'hFFFF);      sign = data_i[15]; end
            2'b10: begin mask = LLEN'(64'hFFFF_FFFF); sign = data_i[31]; end
            default: begin mask = '1;                 sign = 1'b0;       end
        endcase
        ext_o = (sign && !funct3_i[2]) ? (data_i | ~mask) : (data_i & mask);
    end
endmodule

// File: rtl/load_align_merge.sv
// Load align/merge: merges one or two D$ beats, aligns to bit 0 and extends per funct3.
// WALLY_MISALIGNED_LOAD_EN enables two-beat servicing of LLEN-boundary-crossing loads.
module load_align_merge
    import load_align_merge_pkg::*;
#(
    parameter int LLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    load_align_merge_if.slave   bus
);
    localparam int OFFW = $clog2(LLEN/8);

    state_e          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [OFFW-1:0] offset_q, offset_d;
    logic [LLEN-1:0] hold0_q, hold0_d;
    logic [LLEN-1:0] resp_data_q, resp_data_d;
    logic            mis_q, mis_d;

    logic [3:0]        size;
    logic [4:0]        span_sum;
    logic              spans;
    logic [LLEN-1:0]   beat_lo, beat_hi, shifted, extended;
    logic [2*LLEN-1:0] merged;

    assign size     = load_size(funct3_q[1:0], LLEN);
    assign span_sum = 5'(offset_q) + 5'(size);
    assign spans    = span_sum > 5'(LLEN/8);

    // Beat 0 is taken straight off the bus in BEAT0 and from Hold0 in BEAT1.
    assign beat_lo = (state_q == BEAT1) ? hold0_q : bus.BeatData;
    assign beat_hi = (state_q == BEAT1) ? bus.BeatData : '0;
    assign merged  = {beat_hi, beat_lo} >> {offset_q, 3'b000};
    assign shifted = merged[LLEN-1:0];

    subword_extend #(.LLEN(LLEN)) u_ext (
        .data_i   (shifted),
        .funct3_i (funct3_q),
        .ext_o    (extended)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        hold0_d     = hold0_q;
        resp_data_d = resp_data_q;
        mis_d       = mis_q;
        if (state_q != IDLE && bus.Flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (bus.ReqValid) begin
                    funct3_d = bus.Funct3;
                    offset_d = bus.Offset;
                    state_d  = BEAT0;
                end
                BEAT0: if (bus.BeatValid) begin
                    hold0_d = bus.BeatData;
                    if (spans) begin
`ifdef WALLY_MISALIGNED_LOAD_EN
                        state_d = BEAT1;
`else
                        state_d     = RESP;
                        resp_data_d = '0;
                        mis_d       = 1'b1;
`endif
                    end else begin
                        state_d     = RESP;
                        resp_data_d = extended;
                        mis_d       = 1'b0;
                    end
                end
                BEAT1: if (bus.BeatValid) begin
                    state_d     = RESP;
                    resp_data_d = extended;
                    mis_d       = 1'b0;
                end
                RESP: if (bus.RespReady) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            offset_q    <= '0;
            hold0_q     <= '0;
            resp_data_q <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            hold0_q     <= hold0_d;
            resp_data_q <= resp_data_d;
            mis_q       <= mis_d;
        end
    end

    assign bus.ReqReady   = (state_q == IDLE);
    assign bus.RespValid  = (state_q == RESP);
    assign bus.RespData   = resp_data_q;
    assign bus.Misaligned = mis_q;
`ifdef WALLY_MISALIGNED_LOAD_EN
    assign bus.BeatReq    = (state_q == BEAT1);
`else
    assign bus.BeatReq    = 1'b0;
`endif

endmodule

// File: tb/tb_load_align_merge.sv
// Scoreboard bench for load_align_merge (LLEN=64); expectations follow WALLY_MISALIGNED_LOAD_EN.
module tb_load_align_merge;
    import load_align_merge_pkg::*;

    localparam int LLEN = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_align_merge_if #(.LLEN(LLEN)) bus();

    load_align_merge #(.LLEN(LLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.RespValid === 1'b1 && bus.RespReady === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got data %h mis %b with nothing expected",
                         bus.RespData, bus.Misaligned);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", bus.RespData, mon_e.data);
                check("resp_mis", 64'(bus.Misaligned), 64'(mon_e.mis));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] f3, input logic [2:0] off);
        bus.ReqValid = 1'b1;
        bus.Funct3   = f3;
        bus.Offset   = off;
        tick();
        bus.ReqValid = 1'b0;
    endtask

    // Single-beat path: BEAT0 -> RESP, response exactly one cycle after the beat.
    task automatic load1(input string name, input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] data, input logic [63:0] exp_data, input logic exp_mis);
        req(f3, off);
        bus.BeatValid = 1'b1;
        bus.BeatData  = data;
        sb.push_back('{exp_data, exp_mis});
        @(negedge clk);
        check({name, "_beatreq_b0"}, 64'(bus.BeatReq), 64'd0);
        check({name, "_early_valid"}, 64'(bus.RespValid), 64'd0);
        tick();
        bus.BeatValid = 1'b0;
        @(negedge clk);
        check({name, "_latency"}, 64'(bus.RespValid), 64'd1);
        check({name, "_beatreq_resp"}, 64'(bus.BeatReq), 64'd0);
        tick();
    endtask

    // Two-beat path: BeatReq during BEAT1, response one cycle after the second beat.
    task automatic load2(input string name, input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] b0, input logic [63:0] b1, input logic [63:0] exp_data);
        req(f3, off);
        bus.BeatValid = 1'b1;
        bus.BeatData  = b0;
        tick();
        bus.BeatData  = b1;
        sb.push_back('{exp_data, 1'b0});
        @(negedge clk);
        check({name, "_beatreq_b1"}, 64'(bus.BeatReq), 64'd1);
        check({name, "_valid_b1"}, 64'(bus.RespValid), 64'd0);
        tick();
        bus.BeatValid = 1'b0;
        @(negedge clk);
        check({name, "_latency"}, 64'(bus.RespValid), 64'd1);
        check({name, "_beatreq_resp"}, 64'(bus.BeatReq), 64'd0);
        tick();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_reqready"}, 64'(bus.ReqReady), 64'd1);
        check({name, "_beatreq"}, 64'(bus.BeatReq), 64'd0);
        check({name, "_respvalid"}, 64'(bus.RespValid), 64'd0);
        check({name, "_respdata"}, bus.RespData, 64'd0);
        check({name, "_mis"}, 64'(bus.Misaligned), 64'd0);
    endtask

    initial begin
        bus.ReqValid  = 1'b0;
        bus.Funct3    = 3'b000;
        bus.Offset    = 3'd0;
        bus.BeatValid = 1'b0;
        bus.BeatData  = '0;
        bus.Flush     = 1'b0;
        bus.RespReady = 1'b1;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        tick();

        load1("lb_off3",  F3_LB,  3'd3, 64'h00000000_F0000000, 64'hFFFFFFFF_FFFFFFF0, 1'b0);
        load1("lbu_off3", F3_LBU, 3'd3, 64'h00000000_F0000000, 64'h00000000_000000F0, 1'b0);
        load1("lw_off4_edge", F3_LW, 3'd4, 64'h80000001_00000000, 64'hFFFFFFFF_80000001, 1'b0);

`ifdef WALLY_MISALIGNED_LOAD_EN
        load2("lw_span",  F3_LW,  3'd6, 64'hAABB0000_00000000, 64'h00000000_0000CCDD, 64'hFFFFFFFF_CCDDAABB);
        load2("lwu_span", F3_LWU, 3'd6, 64'hAABB0000_00000000, 64'h00000000_0000CCDD, 64'h00000000_CCDDAABB);
`else
        load1("lw_span_trap", F3_LW, 3'd6, 64'hAABB0000_00000000, 64'd0, 1'b1);
`endif

        // Result held stable while the consumer stalls.
        bus.RespReady = 1'b0;
        req(F3_LD, 3'd0);
        bus.BeatValid = 1'b1;
        bus.BeatData  = 64'h81234567_89ABCDEF;
        tick();
        bus.BeatValid = 1'b0;
        sb.push_back('{64'h81234567_89ABCDEF, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.RespValid), 64'd1);
            check("stall_data", bus.RespData, 64'h81234567_89ABCDEF);
            check("stall_reqready", 64'(bus.ReqReady), 64'd0);
            tick();
        end
        bus.RespReady = 1'b1;
        tick();
        @(negedge clk);
        check("stall_exit_reqready", 64'(bus.ReqReady), 64'd1);
        check("stall_exit_valid", 64'(bus.RespValid), 64'd0);
        tick();

        // Flush with a simultaneous beat drops the load.
        req(F3_LW, 3'd6);
`ifdef WALLY_MISALIGNED_LOAD_EN
        bus.BeatValid = 1'b1;
        bus.BeatData  = 64'hAABB0000_00000000;
        tick();
        bus.BeatData  = 64'h00000000_0000CCDD;
`else
        bus.BeatValid = 1'b1;
        bus.BeatData  = 64'hAABB0000_00000000;
`endif
        bus.Flush = 1'b1;
        tick();
        bus.Flush     = 1'b0;
        bus.BeatValid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(bus.RespValid), 64'd0);
        check("flush_reqready", 64'(bus.ReqReady), 64'd1);
        check("flush_beatreq", 64'(bus.BeatReq), 64'd0);
        tick();
        load1("lh_after_flush", F3_LH, 3'd0, 64'h00000000_00007FFF, 64'h00000000_00007FFF, 1'b0);

        // Asynchronous reset mid-load.
        req(F3_LW, 3'd6);
`ifdef WALLY_MISALIGNED_LOAD_EN
        bus.BeatValid = 1'b1;
        bus.BeatData  = 64'hAABB0000_00000000;
        tick();
        bus.BeatValid = 1'b0;
        @(negedge clk);
        check("pre_reset_beatreq", 64'(bus.BeatReq), 64'd1);
`endif
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
        load1("lb_after_reset", F3_LB, 3'd0, 64'h00000000_00000080, 64'hFFFFFFFF_FFFFFF80, 1'b0);

        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d responses still expected, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, required completion by 50000");
        $fatal(1);
    end

endmodule
